// File: rtl/instr_encoder.sv
// instr_encoder: turns mnemonic-level requests into 32-bit MIPS-style
// instruction words and writes them sequentially into an instruction memory,
// stopping at a halt word or when the memory runs out of addresses.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W:0]   FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [4:0]        MNEM_HALT = 5'd27;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic [31:0]       word_q, word_n;
  logic              halt_q, halt_n;
  logic              err_q, err_n;
  logic              ovf_q, ovf_n;
  logic              accept;
  logic [31:0]       enc_word;

  // Unused R-type fields are forced to zero so the memory image is canonical.
  function automatic logic [31:0] encode(
    input logic [4:0]  m,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_sh,
    input logic [15:0] f_imm,
    input logic [25:0] f_tgt
  );
    logic [31:0] w;
    w = 32'hFFFF_FFFF;
    case (m)
      5'd0:  w = {6'h00, 5'd0, f_rt, f_rd, f_sh, 6'h00};
      5'd1:  w = {6'h00, 5'd0, f_rt, f_rd, f_sh, 6'h02};
      5'd2:  w = {6'h00, 5'd0, f_rt, f_rd, f_sh, 6'h03};
      5'd3:  w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h04};
      5'd4:  w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h06};
      5'd5:  w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h07};
      5'd6:  w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h20};
      5'd7:  w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h21};
      5'd8:  w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h22};
      5'd9:  w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h23};
      5'd10: w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h24};
      5'd11: w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h25};
      5'd12: w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h26};
      5'd13: w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h27};
      5'd14: w = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h2a};
      5'd15: w = {6'h00, f_rs, 5'd0, 5'd0, 5'd0, 6'h08};
      5'd16: w = {6'h04, f_rs, f_rt, f_imm};
      5'd17: w = {6'h05, f_rs, f_rt, f_imm};
      5'd18: w = {6'h08, f_rs, f_rt, f_imm};
      5'd19: w = {6'h09, f_rs, f_rt, f_imm};
      5'd20: w = {6'h0c, f_rs, f_rt, f_imm};
      5'd21: w = {6'h0d, f_rs, f_rt, f_imm};
      5'd22: w = {6'h0e, f_rs, f_rt, f_imm};
      5'd23: w = {6'h23, f_rs, f_rt, f_imm};
      5'd24: w = {6'h2b, f_rs, f_rt, f_imm};
      5'd25: w = {6'h02, f_tgt};
      5'd26: w = {6'h03, f_tgt};
      default: w = 32'hFFFF_FFFF;
    endcase
    return w;
  endfunction

  // Reset gates the handshake and the write strobe immediately, not a cycle later.
  assign req_ready = (state == IDLE) && !reset;
  assign mem_we    = (state == WRITE) && !reset;
  assign mem_addr  = ptr;
  assign mem_wdata = word_q;
  assign count     = cnt;
  assign done      = (state == DONE);
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign accept    = req_valid && req_ready;
  assign enc_word  = encode(mnem, rs, rt, rd, shamt, imm, target);

  // Next-state and datapath update; the pointer never wraps and count saturates.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    word_n  = word_q;
    halt_n  = halt_q;
    err_n   = err_q;
    ovf_n   = ovf_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mnem <= MNEM_HALT) begin
            word_n  = enc_word;
            halt_n  = (mnem == MNEM_HALT);
            state_n = WRITE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      WRITE: begin
        if (ptr != LAST) ptr_n = ptr + 1'b1;
        if (cnt != FULL) cnt_n = cnt + 1'b1;
        if (halt_q) begin
          state_n = DONE;
        end else if (ptr == LAST) begin
          ovf_n   = 1'b1;
          state_n = DONE;
        end else begin
          state_n = IDLE;
        end
      end
      DONE: begin
        if (clear) begin
          state_n = IDLE;
          ptr_n   = BASE;
          cnt_n   = '0;
          err_n   = 1'b0;
          ovf_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with synchronous reset, which also wins over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= BASE;
      cnt    <= '0;
      word_q <= '0;
      halt_q <= 1'b0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      word_q <= word_n;
      halt_q <= halt_n;
      err_q  <= err_n;
      ovf_q  <= ovf_n;
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning the first word address written after reset or clear.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  encoder can accept a request.
REQ-007 SHALL have port mnem  input  5  mnemonic code: 0 sll, 1 srl, 2 sra, 3 sllv, 4 srlv, 5 srav, 6 add, 7 addu, 8 sub, 9 subu, 10 and, 11 or, 12 xor, 13 nor, 14 slt, 15 jr, 16 beq, 17 bne, 18 addi, 19 addiu, 20 andi, 21 ori, 22 xori, 23 lw, 24 sw, 25 j, 26 jal, 27 halt.
REQ-008 SHALL have ports rs, rt, rd, shamt  input  5 each  register and shift-amount fields.
REQ-009 SHALL have ports imm  input  16 and target  input  26, the immediate and jump-target fields.
REQ-010 SHALL have port clear  input  1  in DONE, restarts the encoder at BASE_ADDR.
REQ-011 SHALL have ports mem_we  output  1, mem_addr  output  ADDR_W, and mem_wdata  output  32, forming the instruction-memory write port.
REQ-012 SHALL have port count  output  ADDR_W+1  words written since reset or clear.
REQ-013 SHALL have ports done  output  1, err  output  1 (sticky, illegal mnemonic), and ovf  output  1 (sticky, memory exhausted).

Function
REQ-014 SHALL implement the states IDLE, WRITE and DONE.
REQ-015 SHALL drive req_ready = 1 only in IDLE and not in reset.
REQ-016 SHALL accept a request on a rising edge with req_valid && req_ready, and register the encoded word on that edge.
REQ-017 SHALL, for an accepted mnem <= 27, move IDLE -> WRITE.
REQ-018 SHALL, for an accepted mnem > 27, set err, stay in IDLE and perform no write.
REQ-019 SHALL drive mem_we = 1 for exactly the one cycle spent in WRITE, with mem_addr = the write pointer and mem_wdata = the registered word.
REQ-020 SHALL, on leaving WRITE, increment the pointer and count.
- Next state is DONE if the word was halt; otherwise IDLE.
- Latency is 2 cycles from acceptance; peak throughput is 1 word per 2 cycles.
REQ-021 SHALL encode R-type words as op=0 with rs[25:21], rt[20:16], rd[15:11], shamt[10:6] and funct[5:0].
- Funct values: sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07, jr 08, add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2a (hex).
REQ-022 SHALL force R-type fields to zero where unused.
- sll/srl/sra: rs = 0.
- Variable shifts and ALU operations: shamt = 0.
- jr: rt = rd = shamt = 0.
REQ-023 SHALL encode I-type words as op[31:26], rs, rt, imm[15:0].
- Opcodes: beq 04, bne 05, addi 08, addiu 09, andi 0c, ori 0d, xori 0e, lw 23, sw 2b (hex).
REQ-024 SHALL encode j as op 02 and jal as op 03, each followed by target[25:0].
REQ-025 SHALL encode halt as 32'hFFFFFFFF.
REQ-026 SHALL handle a non-halt write at address 2^ADDR_W-1 as memory exhaustion.
- Set ovf and go to DONE.
- No pointer wrap-around; count saturates at 2^ADDR_W.
REQ-027 SHALL drive done = 1 in DONE, where req_ready = 0.
REQ-028 SHALL, on clear in DONE, return to IDLE with pointer = BASE_ADDR, count = 0 and err = ovf = 0; clear SHALL be ignored in any other state.
REQ-029 SHALL, with reset and clear both asserted, apply reset.

Reset
REQ-030 SHALL, on reset, set state = IDLE, pointer = BASE_ADDR and count = 0, and clear done, err and ovf.
REQ-031 SHALL gate mem_we combinationally with reset, so a reset asserted during WRITE suppresses that write, and the word is discarded.
REQ-032 SHALL hold mem_wdata and mem_addr at 0 and BASE_ADDR after reset until the first accepted request.

Verification
REQ-033 SHALL verify that add rs=1 rt=2 rd=3 produces mem_we at addr 0 with word 0x00221820 two cycles after acceptance, and count = 1.
REQ-034 SHALL verify that sll rd=2 rt=1 shamt=4 rs=7 produces 0x00011100, with rs masked.
REQ-035 SHALL verify that addi rt=5 rs=0 imm=0xFFFF produces 0x2005FFFF, and that j target=0x10 produces 0x08000010 at consecutive addresses.
REQ-036 SHALL verify that mnem = 30 produces no write, err = 1, and leaves the pointer unchanged; the following halt writes 0xFFFFFFFF, then done = 1 and req_ready = 0.
REQ-037 SHALL verify, with ADDR_W = 2, that four non-halt writes produce ovf = 1, done = 1 and count = 4, and that clear returns to IDLE at addr 0.
REQ-038 SHALL verify that reset asserted during WRITE produces mem_we = 0 in that cycle, and that the next state is IDLE with count = 0.
